// File: rtl/act_skew_feeder.sv
// act_skew_feeder: FIFO-buffered activation feeder that emits each vector diagonally skewed across rows.
// Optional `define ACT_SKEW_STALL_CNT_EN adds a saturating stall_count output.
module act_skew_feeder #(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned ACT_W = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROWS*ACT_W-1:0] in_vec,
  input  logic                  in_last,
  input  logic                  weight_load,
  output logic [ROWS*ACT_W-1:0] out_act,
  output logic [ROWS-1:0]       out_row_valid,
  output logic                  busy,
  output logic                  done
`ifdef ACT_SKEW_STALL_CNT_EN
  ,
  output logic [15:0]           stall_count
`endif
);

  localparam int unsigned VW = ROWS * ACT_W;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned DW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

  state_t        state, state_n;
  logic [DW-1:0] drain_cnt, drain_cnt_n;

  logic [VW:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;
  logic [VW-1:0] rd_vec;
  logic          rd_last;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign {rd_last, rd_vec} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem[wr_ptr] <= {in_last, in_vec};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_n;
      drain_cnt <= drain_cnt_n;
    end
  end

  // Pops only happen in STREAM; weight_load freezes state, counter and pops together.
  always_comb begin
    state_n     = state;
    drain_cnt_n = drain_cnt;
    pop         = 1'b0;
    if (!weight_load) begin
      case (state)
        S_IDLE: begin
          if (push || !empty) state_n = S_STREAM;
        end
        S_STREAM: begin
          if (!empty) begin
            pop = 1'b1;
            if (rd_last) begin
              state_n     = S_DRAIN;
              drain_cnt_n = DRAIN_INIT;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) state_n = S_IDLE;
          else                 drain_cnt_n = drain_cnt - 1'b1;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // done coincides with the last row presenting the final element of the tile.
  assign done = (state == S_DRAIN) && (drain_cnt == '0) && !weight_load;
  assign busy = (state != S_IDLE);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [r:0][ACT_W-1:0] sd;
    logic [r:0]            sv;
    logic [ACT_W-1:0]      s0_d;

    assign s0_d = pop ? rd_vec[r*ACT_W +: ACT_W] : '0;

    if (r == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (!reset) begin
          sd <= '0;
          sv <= '0;
        end else if (!weight_load) begin
          sd <= s0_d;
          sv <= pop;
        end
      end
    end else begin : g_chain
      always_ff @(posedge clk) begin
        if (!reset) begin
          sd <= '0;
          sv <= '0;
        end else if (!weight_load) begin
          sd <= {sd[r-1:0], s0_d};
          sv <= {sv[r-1:0], pop};
        end
      end
    end

    assign out_act[r*ACT_W +: ACT_W] = weight_load ? '0 : sd[r];
    assign out_row_valid[r]          = sv[r] && !weight_load;
  end

`ifdef ACT_SKEW_STALL_CNT_EN
  logic stall_evt;
  assign stall_evt = (in_valid && !in_ready) || ((state == S_STREAM) && empty);

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (stall_evt && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_act_skew_feeder.sv
// Randomized bench for act_skew_feeder against a queue/history-based model, plus literal pinning checks.
module tb_act_skew_feeder;
  localparam int ROWS  = 4;
  localparam int ACT_W = 8;
  localparam int DEPTH = 8;
  localparam int VW    = ROWS * ACT_W;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, in_last, weight_load, busy, done;
  logic [VW-1:0] in_vec, out_act;
  logic [ROWS-1:0] out_row_valid;
`ifdef ACT_SKEW_STALL_CNT_EN
  logic [15:0]   stall_count;
`endif

  act_skew_feeder #(.ROWS(ROWS), .ACT_W(ACT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .in_last(in_last), .weight_load(weight_load),
    .out_act(out_act), .out_row_valid(out_row_valid), .busy(busy), .done(done)
`ifdef ACT_SKEW_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { bit last; logic [VW-1:0] vec; } ent_t;
  typedef struct { bit v;    logic [VW-1:0] vec; } slot_t;

  // Model: FIFO as a queue; each row's output is the stage-0 value from r non-held edges ago.
  ent_t  fifo_q[$];
  slot_t hist[$];
  bit    m_stream, m_drain;
  int    m_left;
  int unsigned m_stall;

  int checks = 0, errors = 0, cyc = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    logic [VW-1:0]   e_act;
    logic [ROWS-1:0] e_v;
    slot_t s;
    int idx;
    e_act = '0;
    e_v   = '0;
    if (!weight_load) begin
      for (int r = 0; r < ROWS; r++) begin
        idx = hist.size() - 1 - r;
        if (idx >= 0) begin
          s = hist[idx];
          if (s.v) begin
            e_v[r] = 1'b1;
            e_act[r*ACT_W +: ACT_W] = s.vec[r*ACT_W +: ACT_W];
          end
        end
      end
    end
    chk("in_ready", in_ready, fifo_q.size() < DEPTH);
    chk("busy", busy, m_stream || m_drain);
    chk("done", done, m_drain && (m_left == 0) && !weight_load);
    chk("out_row_valid", out_row_valid, e_v);
    chk("out_act", out_act, e_act);
`ifdef ACT_SKEW_STALL_CNT_EN
    chk("stall_count", stall_count, m_stall);
`endif
  endtask

  task automatic model_step();
    bit full, do_push, do_pop, was_idle_nonempty;
    ent_t head, e;
    slot_t s;
    if (!reset) begin
      fifo_q.delete();
      hist.delete();
      m_stream = 0; m_drain = 0; m_left = 0; m_stall = 0;
      return;
    end
    full    = fifo_q.size() >= DEPTH;
    do_push = in_valid && !full;
    do_pop  = !weight_load && m_stream && (fifo_q.size() > 0);
    was_idle_nonempty = fifo_q.size() > 0;
    if ((in_valid && full) || (m_stream && fifo_q.size() == 0))
      if (m_stall < 65535) m_stall++;
    head.last = 0;
    head.vec  = '0;
    if (!weight_load) begin
      if (do_pop) begin
        head  = fifo_q.pop_front();
        s.v   = 1'b1;
        s.vec = head.vec;
      end else begin
        s.v   = 1'b0;
        s.vec = '0;
      end
      hist.push_back(s);
      if (hist.size() > ROWS) void'(hist.pop_front());
      if (m_drain) begin
        if (m_left == 0) m_drain = 0;
        else m_left--;
      end else if (m_stream) begin
        if (do_pop && head.last) begin
          m_stream = 0; m_drain = 1; m_left = ROWS - 1;
        end
      end else if (do_push || was_idle_nonempty) begin
        m_stream = 1;
      end
    end
    if (do_push) begin
      e.last = in_last;
      e.vec  = in_vec;
      fifo_q.push_back(e);
    end
  endtask

  task automatic cycle(input bit rst, input bit iv, input bit lst, input bit wl, input logic [VW-1:0] v);
    reset = rst; in_valid = iv; in_last = lst; weight_load = wl; in_vec = v;
    #1;
    if (chk_en) compare_all();
    model_step();
    @(negedge clk);
    cyc++;
    chk_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, '0);
  endtask

  task automatic do_reset();
    cycle(0, 0, 0, 0, '0);
    cycle(0, 0, 0, 0, '0);
  endtask

  initial begin
    bit hold;
    logic [VW-1:0] hv;
    bit hl;
    logic [VW-1:0] fv;
    @(negedge clk);
    do_reset();

    // single vector, literal wavefront
    chk("t1_reset_ready", in_ready, 1'b1);
    chk("t1_reset_busy", busy, 1'b0);
    cycle(1, 1, 1, 0, 32'h04030201);
    chk("t1_busy", busy, 1'b1);
    chk("t1_rv0", out_row_valid, 4'b0000);
    idle(1);
    chk("t1_rv1", out_row_valid, 4'b0001);
    chk("t1_row0", out_act[7:0], 8'd1);
    idle(1);
    chk("t1_rv2", out_row_valid, 4'b0010);
    chk("t1_row1", out_act[15:8], 8'd2);
    idle(1);
    chk("t1_rv3", out_row_valid, 4'b0100);
    chk("t1_row2", out_act[23:16], 8'd3);
    idle(1);
    chk("t1_rv4", out_row_valid, 4'b1000);
    chk("t1_row3", out_act[31:24], 8'd4);
    chk("t1_done", done, 1'b1);
    idle(1);
    chk("t1_done_end", done, 1'b0);
    chk("t1_idle", busy, 1'b0);

    // back-to-back tile
    for (int i = 0; i < 4; i++) cycle(1, 1, i == 3, 0, $urandom);
    idle(8);

    // fill while frozen, then release
    do_reset();
    fv = 32'hA5A5_0000;
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 1, fv + i);
    chk("t3_full_ready", in_ready, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 1, 32'hDEAD_BEEF);
`ifdef ACT_SKEW_STALL_CNT_EN
    chk("t3_stall5", stall_count, 16'd5);
`endif
    chk("t3_no_pop", busy, 1'b0);
    idle(1);
    chk("t3_ready_before_pop", in_ready, 1'b0);
    idle(1);
    chk("t3_ready_after_pop", in_ready, 1'b1);
    idle(14);

    // weight_load mid-stream
    for (int i = 0; i < 6; i++) begin
      cycle(1, 1, i == 5, (i == 3) || (i == 4), $urandom);
      if (i == 3 || i == 4) begin
        chk("t4_hold_rv", out_row_valid, 4'b0000);
        chk("t4_hold_act", out_act, 32'h0);
      end
    end
    idle(10);

    // reset during drain with two queued vectors
    cycle(1, 1, 1, 0, $urandom);
    cycle(1, 1, 0, 0, $urandom);
    cycle(1, 1, 0, 0, $urandom);
    idle(1);
    chk("t5_in_drain", busy, 1'b1);
    cycle(0, 0, 0, 0, '0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_rv", out_row_valid, 4'b0000);
    chk("t5_done", done, 1'b0);
    chk("t5_ready", in_ready, 1'b1);
    idle(6);

    // randomized traffic
    hold = 0; hv = '0; hl = 0;
    repeat (3000) begin
      bit iv, wl, rst, lst, full_now;
      logic [VW-1:0] v;
      rst = ($urandom_range(0, 299) != 0);
      wl  = ($urandom_range(0, 9) == 0);
      if (hold) begin
        iv = 1; v = hv; lst = hl;
      end else begin
        iv  = ($urandom_range(0, 2) != 0);
        v   = $urandom;
        lst = ($urandom_range(0, 4) == 0);
      end
      full_now = fifo_q.size() >= DEPTH;
      cycle(rst, iv, lst, wl, v);
      hold = iv && full_now && rst;
      hv = v; hl = lst;
    end
    idle(12);

`ifdef ACT_SKEW_STALL_CNT_EN
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 1, fv + i);
    for (int i = 0; i < 65535 + 10; i++) cycle(1, 1, 0, 1, 32'h1234_5678);
    chk("stall_saturate", stall_count, 16'hFFFF);
    idle(1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/act_skew_feeder.md
Name: act_skew_feeder

Overview:
- Upstream feeder for the systolic array's activation inputs (the in_act port of the left-column PEs).
- Accepts one N-element activation vector per handshake and buffers it in a small FIFO.
- Emits each vector diagonally skewed: row r gets element r delayed r cycles, giving the wavefront the array needs.
- Freezes and forces zero activations while the array is in weight-load mode. Drains the skew line after the last vector and pulses done.

Parameters:
ROWS, 4, array rows = elements per vector
ACT_W, 8, activation width per element
DEPTH, 8, FIFO depth in vectors (power of 2, >=2)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-low reset (clears when 0 at rising edge)
in_valid  input  1  upstream vector valid
in_ready  output  1  FIFO can accept (= !full)
in_vec  input  ROWS*ACT_W  element r at bits [r*ACT_W +: ACT_W]
in_last  input  1  marks final vector of a tile
weight_load  input  1  array in weight-load phase (same signal as PE en_weight_pass)
out_act  output  ROWS*ACT_W  per-row activation to array row r
out_row_valid  output  ROWS  row r carries a real element this cycle
busy  output  1  state != IDLE
done  output  1  one-cycle pulse when drain completes

Behaviour:
- Reset (reset==0 at edge):
  - FIFO empty, all skew registers 0, out_act=0, out_row_valid=0, done=0, state=IDLE.
  - Applies mid-operation too: in-flight data is discarded, no done pulse.
  - in_ready=1 the cycle after reset deasserts.
- Handshake:
  - Push on edge with in_valid && in_ready.
  - in_ready=!full, with no push-when-full bypass.
  - in_vec/in_last must hold while in_valid && !in_ready.
- FIFO:
  - Entries are {in_last, in_vec}, with count 0..DEPTH.
  - Push and pop on the same edge leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- Pop: at an edge where FIFO non-empty && !weight_load.
- Skew line:
  - Row r has a chain of r+1 registers of {valid, data}. Row 0 has depth 1.
  - Stage 0 of every row loads its element from the popped vector with valid=1.
  - If there is no pop and weight_load=0, stage 0 loads {0, 0} (a bubble).
  - Chains shift every edge where weight_load=0.
  - When weight_load=1, all chains hold and out_act is forced to 0. out_row_valid is forced to 0.
- Latency:
  - A vector pushed into an empty FIFO at edge k is popped at edge k+1 (if weight_load=0).
  - Row r outputs it from edge k+1+r until edge k+2+r.
  - Back-to-back pushes give one vector per cycle per row.
- Output: out_act row r = last stage data; out_row_valid[r] = last stage valid.
- State machine:
  - IDLE -> STREAM on first push.
  - STREAM -> DRAIN on the edge that pops a vector with last=1. A drain counter is loaded with ROWS-1.
  - DRAIN: decrement on each non-held edge. No pops occur in DRAIN.
  - Pushes are still accepted in DRAIN and wait in the FIFO.
  - At counter 0 on a non-held edge, go to IDLE and assert done for 1 cycle.
  - If the FIFO is then non-empty, the next edge enters STREAM.
  - ROWS=1: DRAIN lasts one cycle.
- An empty FIFO in STREAM produces bubbles and stays in STREAM.
- weight_load=1 in any state freezes the state, counter and FIFO pops. Pushes continue.

Optional Feature:
- Macro ACT_SKEW_STALL_CNT_EN.
- When defined:
  - Adds output port stall_count (16 bits).
  - Saturating count of cycles with in_valid && !in_ready, plus cycles in STREAM with FIFO empty (underflow bubbles).
  - Cleared by reset only, and sticks at 16'hFFFF.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset then a single vector {4,3,2,1} (row0=1) with in_last=1 pushed at edge k:
  - row0=1 valid at k+1, row1=2 at k+2, row2=3 at k+3, row3=4 at k+4.
  - done pulses after edge k+4 (drain of 3). busy returns to 0.
- Four back-to-back vectors V0..V3, last on V3:
  - Each row outputs V0..V3 elements on consecutive cycles.
  - out_row_valid has a diagonal rising/falling pattern. done fires exactly 3 cycles after the V3 pop.
- Fill with in_valid held high and weight_load=1:
  - in_ready drops after 8 pushes. count holds at 8 and there are no pops.
  - Release weight_load: one pop per cycle, and in_ready returns 1 cycle after the first pop.
- weight_load asserted 2 cycles mid-stream:
  - out_act=0 and out_row_valid=0 for those cycles.
  - After release, the sequence resumes unchanged with no lost or duplicated elements.
- reset=0 during DRAIN with 2 vectors queued: next cycle outputs 0, FIFO empty, state IDLE, and no done pulse.
- With ACT_SKEW_STALL_CNT_EN:
  - 5 cycles of in_valid held while full -> stall_count=5.
  - Forcing 0xFFFF+10 stall cycles -> saturates at 0xFFFF.
